// File: rtl/pp_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : pp_accumulator_if
// Description : Handshake bundle for the partial-product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface pp_accumulator_if #(
    parameter int W = 8
);
    logic [W*W-1:0] pp;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] product;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    modport master (
        output pp, in_valid, out_ready,
        input  in_ready, product, out_valid, busy
    );

    modport slave (
        input  pp, in_valid, out_ready,
        output in_ready, product, out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : pp_accumulator
// Description : Sums a WxW partial-product matrix one row per cycle into a
//               2W-bit product, with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_accumulator #(
    parameter int W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pp_accumulator_if.slave    bus
);

    localparam int JW = (W > 1) ? $clog2(W) : 1;
    localparam logic [JW-1:0] c_J_LAST = JW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [W*W-1:0]  r_pp;
    logic [2*W-1:0]  r_acc;
    logic [JW-1:0]   r_j;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;
    logic [2*W-1:0]  r_product;

    logic [W-1:0]    w_row;
    logic [2*W-1:0]  w_acc_next;

    always_comb begin
        w_row = '0;
        for (int k = 0; k < W; k++) begin
            if (r_j == JW'(k)) begin
                w_row = r_pp[W*k +: W];
            end
        end
    end

    assign w_acc_next = r_acc + ({{W{1'b0}}, w_row} << r_j);

    // Outputs are registered alongside the state so product is forced to
    // zero in every cycle where out_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pp        <= '0;
            r_acc       <= '0;
            r_j         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_pp       <= bus.pp;
                        r_acc      <= '0;
                        r_j        <= '0;
                        r_state    <= S_ACCUM;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_acc_next;
                    if (r_j == c_J_LAST) begin
                        r_j         <= '0;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_product   <= w_acc_next;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_product   <= '0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_product   <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pp_accumulator
// Description : Scoreboard bench for pp_accumulator with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_accumulator;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;
    bit   mon_en;

    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];
    int             last_acc;

    pp_accumulator_if #(.W(W)) bus ();

    pp_accumulator #(.W(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W*W-1:0] mk_pp(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W*W-1:0] p;
        p = '0;
        for (int j = 0; j < W; j++)
            for (int i = 0; i < W; i++)
                p[W*j+i] = a[i] & b[j];
        return p;
    endfunction

    // Monitor: samples 2 time units after each falling edge.
    initial begin : monitor
        logic           prev_ov;
        logic           prev_or;
        logic           prev_hs;
        logic [2*W-1:0] prev_prod;
        int             a_cyc;
        logic [2*W-1:0] e;
        prev_ov   = 1'b0;
        prev_or   = 1'b0;
        prev_hs   = 1'b0;
        prev_prod = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("busy_vs_in_ready", {31'b0, bus.busy}, {31'b0, ~bus.in_ready});
                if (!bus.out_valid)
                    chk("product_zero_when_invalid", {16'b0, bus.product}, 32'h0);
                else
                    chk("in_ready_low_in_done", {31'b0, bus.in_ready}, 32'h0);
                if (prev_hs)
                    chk("out_valid_falls_after_hs", {31'b0, bus.out_valid}, 32'h0);
                if (bus.out_valid && !prev_ov) begin
                    chk("valid_has_pending_accept", {31'b0, (acc_q.size() != 0)}, 32'h1);
                    if (acc_q.size() != 0) begin
                        a_cyc = acc_q.pop_front();
                        chk("latency", cyc - a_cyc, W);
                    end
                end
                if (bus.out_valid && prev_ov && !prev_or)
                    chk("product_stable", {16'b0, bus.product}, {16'b0, prev_prod});
                if (bus.out_valid && bus.out_ready) begin
                    chk("result_has_expected", {31'b0, (exp_q.size() != 0)}, 32'h1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("product", {16'b0, bus.product}, {16'b0, e});
                    end
                end
                prev_hs   = bus.out_valid & bus.out_ready;
                prev_ov   = bus.out_valid;
                prev_or   = bus.out_ready;
                prev_prod = bus.product;
            end
        end
    end

    // Issue one transaction; called on a falling edge.
    task automatic send(input logic [W*W-1:0] p, input logic [2*W-1:0] e, input bit keep_valid);
        int t;
        bus.pp       = p;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", {31'b0, bus.in_ready}, 32'h1);
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
            last_acc = cyc + 1;
            @(negedge clk);
            if (!keep_valid) bus.in_valid = 1'b0;
            bus.pp = {$urandom, $urandom};
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 32'h0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready",  {31'b0, bus.in_ready},  32'h1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_busy",      {31'b0, bus.busy},      32'h0);
        chk("rst_product",   {16'b0, bus.product},   32'h0);
    endtask

    initial begin : driver
        int t;
        int a0;
        logic [W*W-1:0] p_rows;
        logic [W-1:0]   va[4];
        logic [W-1:0]   vb[4];
        logic [2*W-1:0] ve[4];

        n_vec = 0;
        n_err = 0;
        mon_en = 1'b0;
        last_acc = 0;
        rst_n = 1'b0;
        bus.pp = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_vals();
        mon_en = 1'b1;
        @(negedge clk);

        send(mk_pp(8'h03, 8'h05), 16'h000F, 1'b0);
        wait_idle();
        send(mk_pp(8'hFF, 8'hFF), 16'hFE01, 1'b0);
        wait_idle();
        send('0, 16'h0000, 1'b0);
        wait_idle();

        // Arbitrary bit pattern: every row holds only bit 0.
        p_rows = '0;
        for (int j = 0; j < W; j++) p_rows[W*j] = 1'b1;
        send(p_rows, 16'h00FF, 1'b0);
        wait_idle();

        // Backpressure in DONE.
        bus.out_ready = 1'b0;
        send(mk_pp(8'h0C, 8'h0A), 16'h0078, 1'b0);
        t = 0;
        while (!bus.out_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("bp_reached_done", {31'b0, bus.out_valid}, 32'h1);
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_released_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("bp_released_ready", {31'b0, bus.in_ready},  32'h1);
        wait_idle();

        // in_valid held high with a different pp while busy.
        send(mk_pp(8'h12, 8'h34), 16'h03A8, 1'b1);
        a0 = last_acc;
        send(mk_pp(8'h0F, 8'h11), 16'h00FF, 1'b0);
        chk("held_accept_spacing", last_acc - a0, 32'd10);
        wait_idle();

        // Reset in the 4th ACCUM cycle discards the transaction.
        bus.pp = mk_pp(8'h55, 8'h66);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_vals();
        repeat (12) @(negedge clk);
        chk("no_valid_after_reset", {31'b0, bus.out_valid}, 32'h0);
        send(mk_pp(8'h07, 8'h09), 16'h003F, 1'b0);
        wait_idle();

        // Back-to-back with out_ready tied high.
        va[0] = 8'hA5; vb[0] = 8'h5A; ve[0] = 16'h3A02;
        va[1] = 8'h80; vb[1] = 8'h80; ve[1] = 16'h4000;
        va[2] = 8'h01; vb[2] = 8'hFF; ve[2] = 16'h00FF;
        va[3] = 8'hAB; vb[3] = 8'hCD; ve[3] = 16'h88EF;
        for (int k = 0; k < 4; k++) begin
            a0 = last_acc;
            send(mk_pp(va[k], vb[k]), ve[k], 1'b0);
            if (k > 0) chk("b2b_spacing", last_acc - a0, 32'd10);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("acc_queue_empty", acc_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
